freq_tick_gen: RTL and testbench

FREQ_TICK_GEN -- requirements
Module: freq_tick_gen

---
 rtl/freq_tick_gen.sv | 160 ++++++++++++++++
 tb/tb_freq_tick_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_tick_gen.sv
// Selectable-rate tick generator (BASE_DIV >> sel cycles per tick) with a pause/resume pushbutton.
// Define FREQ_TICK_DEBOUNCE_EN to include the debouncer FSM; otherwise the press is a synchronized rising edge.
module freq_tick_gen #(
  parameter int unsigned BASE_DIV  = 50000000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sel,
  input  logic       btn_pause,
  output logic       tick,
  output logic       paused,
  output logic [2:0] sel_active
);

  localparam int          CNT_W  = $clog2(BASE_DIV);
  localparam logic [31:0] BASE_U = 32'(BASE_DIV);

  logic [2:0]       r_sel_p0;
  logic [2:0]       r_sel_p1;
  logic             r_btn_p0;
  logic             r_btn_p1;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel_act;
  logic             r_tick;
  logic             r_paused;
  logic [31:0]      w_last;
  logic             w_wrap;
  logic             w_press;

  // Two-flop synchronizers for the asynchronous switches and pushbutton.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_p0 <= '0;
      r_sel_p1 <= '0;
      r_btn_p0 <= 1'b0;
      r_btn_p1 <= 1'b0;
    end else begin
      r_sel_p0 <= sel;
      r_sel_p1 <= r_sel_p0;
      r_btn_p0 <= btn_pause;
      r_btn_p1 <= r_btn_p0;
    end
  end

`ifdef FREQ_TICK_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM_HI, HELD, ARM_LO} db_state_t;

  db_state_t       r_db_state;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_db_done;

  assign w_db_done = (r_db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_state <= IDLE;
      r_db_cnt   <= '0;
    end else begin
      case (r_db_state)
        IDLE: begin
          if (r_btn_p1) begin
            r_db_state <= ARM_HI;
            r_db_cnt   <= '0;
          end
        end
        ARM_HI: begin
          if (!r_btn_p1) begin
            r_db_state <= IDLE;
            r_db_cnt   <= '0;
          end else if (w_db_done) begin
            r_db_state <= HELD;
            r_db_cnt   <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!r_btn_p1) begin
            r_db_state <= ARM_LO;
            r_db_cnt   <= '0;
          end
        end
        ARM_LO: begin
          if (r_btn_p1) begin
            r_db_state <= HELD;
            r_db_cnt   <= '0;
          end else if (w_db_done) begin
            r_db_state <= IDLE;
            r_db_cnt   <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        default: begin
          r_db_state <= IDLE;
          r_db_cnt   <= '0;
        end
      endcase
    end
  end

  // Press is decoded from the registered state so paused flips on the same edge HELD is entered.
  assign w_press = (r_db_state == ARM_HI) && r_btn_p1 && w_db_done;
`else
  logic r_btn_p2;
  logic w_unused_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_p2 <= 1'b0;
    end else begin
      r_btn_p2 <= r_btn_p1;
    end
  end

  assign w_press     = r_btn_p1 & ~r_btn_p2;
  assign w_unused_db = ^(32'(DB_CYCLES));
`endif

  assign w_last = (BASE_U >> r_sel_act) - 32'd1;
  assign w_wrap = (32'(r_cnt) == w_last);

  // Prescaler: rate changes only at a period boundary while running, immediately while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_sel_act <= '0;
      r_tick    <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      if (!r_paused) begin
        r_tick <= w_wrap;
        if (w_wrap) begin
          r_cnt     <= '0;
          r_sel_act <= r_sel_p1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_tick <= 1'b0;
        if (r_sel_p1 != r_sel_act) begin
          r_sel_act <= r_sel_p1;
          r_cnt     <= '0;
        end
      end
      if (w_press) begin
        r_paused <= ~r_paused;
      end
    end
  end

  assign tick       = r_tick;
  assign paused     = r_paused;
  assign sel_active = r_sel_act;

endmodule

// File: tb/tb_freq_tick_gen.sv
// Testbench for freq_tick_gen: directed scenarios plus randomized traffic against a cycle reference model.
// Honors FREQ_TICK_DEBOUNCE_EN the same way the design does.
module tb_freq_tick_gen;

  localparam int BASE = 128;
  localparam int DB   = 4;
`ifdef FREQ_TICK_DEBOUNCE_EN
  localparam int PRESS_LAT   = 2 + DB + 1;
  localparam int BOUNCE_TOGS = 0;
`else
  localparam int PRESS_LAT   = 3;
  localparam int BOUNCE_TOGS = 5;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sel;
  logic       btn_pause;
  logic       tick;
  logic       paused;
  logic [2:0] sel_active;

  freq_tick_gen #(.BASE_DIV(BASE), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .btn_pause  (btn_pause),
    .tick       (tick),
    .paused     (paused),
    .sel_active (sel_active)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;

  // Reference model state: input delay lines, accepted button level and run length, period position.
  int m_ss1, m_ss2, m_bs1, m_bs2, m_bs3;
  int m_level, m_run;
  int m_pos, m_rate, m_paused;
  bit m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_ss1 = 0; m_ss2 = 0; m_bs1 = 0; m_bs2 = 0; m_bs3 = 0;
    m_level = 0; m_run = 0;
    m_pos = 0; m_rate = 0; m_paused = 0; m_tick = 1'b0;
  endtask

  // A press is accepted once the synchronized button has disagreed with the accepted level
  // for DB+1 consecutive samples (first disagreement plus DB stable samples).
  task automatic model_edge();
    int  period;
    bit  press;
    press = 1'b0;
`ifdef FREQ_TICK_DEBOUNCE_EN
    if (m_bs2 != m_level) begin
      m_run++;
      if (m_run == DB + 1) begin
        press   = (m_bs2 == 1);
        m_level = m_bs2;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
`else
    press = (m_bs2 == 1) && (m_bs3 == 0);
`endif
    period = BASE >> m_rate;
    if (m_paused == 0) begin
      m_tick = (m_pos == period - 1);
      if (m_tick) begin
        m_pos  = 0;
        m_rate = m_ss2;
      end else begin
        m_pos++;
      end
    end else begin
      m_tick = 1'b0;
      if (m_ss2 != m_rate) begin
        m_rate = m_ss2;
        m_pos  = 0;
      end
    end
    if (press) m_paused = 1 - m_paused;
    m_bs3 = m_bs2; m_bs2 = m_bs1; m_bs1 = int'(btn_pause);
    m_ss2 = m_ss1; m_ss1 = int'(sel);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("tick", tick, m_tick);
    chk("paused", paused, m_paused);
    chk("sel_active", sel_active, m_rate);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    model_clear();
    repeat (n) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < max);
  endtask

  int n, toggles, held, resume_at, tick_at, len;
  logic prev_paused;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1; sel = 3'd0; btn_pause = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_paused", paused, 0);
    chk("rst_sel_active", sel_active, 0);
    reset = 1'b0;
    cyc = 0;

    // First tick BASE cycles after release, then every BASE cycles.
    wait_tick(200, n);
    chk("first_tick_cycle", n, 128);
    wait_tick(200, n);
    chk("period_sel0", n, 128);

    // Rate change waits for the period boundary.
    apply_reset(2);
    step_n(10);
    sel = 3'd3;
    step_n(117);
    chk("sel_held_mid_period", sel_active, 0);
    step();
    chk("sel_loaded_at_wrap", sel_active, 3);
    chk("tick_at_wrap", tick, 1);
    wait_tick(40, n);
    chk("period_sel3_a", n, 16);
    wait_tick(40, n);
    chk("period_sel3_b", n, 16);
    sel = 3'd7;
    for (int k = 0; k < 40 && sel_active != 3'd7; k++) step();
    chk("sel7_loaded", sel_active, 7);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("tick_every_cycle_sel7", tick, 1);
    end

    // Pause at cnt=40, then resume and finish the held period.
    sel = 3'd0;
    apply_reset(2);
    step_n(40);
    btn_pause = 1'b1;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (paused === 1'b1 && n == 0) n = k;
    end
    btn_pause = 1'b0;
    chk("pause_latency", n, PRESS_LAT);
    held = 40 + PRESS_LAT;
    step_n(30);
    btn_pause = 1'b1;
    resume_at = 0; tick_at = 0;
    for (int k = 1; k <= 300 && tick_at == 0; k++) begin
      step();
      if (k == 12) btn_pause = 1'b0;
      if (paused === 1'b0 && resume_at == 0) resume_at = k;
      if (tick === 1'b1 && tick_at == 0) tick_at = k;
    end
    btn_pause = 1'b0;
    chk("resume_latency", resume_at, PRESS_LAT);
    chk("resume_tick_distance", tick_at - resume_at, 128 - held);

    // Bouncing button: 5 short pulses of 2 cycles.
    apply_reset(2);
    step_n(5);
    prev_paused = paused;
    toggles = 0;
    for (int k = 0; k < 35; k++) begin
      btn_pause = (k < 20) && ((k / 2) % 2 == 0);
      step();
      if (paused !== prev_paused) toggles++;
      prev_paused = paused;
    end
    btn_pause = 1'b0;
    chk("bounce_toggles", toggles, BOUNCE_TOGS);

    // Rate change while paused loads at once and clears the count.
    apply_reset(2);
    step_n(3);
    btn_pause = 1'b1;
    step_n(12);
    btn_pause = 1'b0;
    step_n(10);
    chk("paused_before_sel", paused, 1);
    chk("sel_zero_before_sel", sel_active, 0);
    sel = 3'd5;
    step_n(2);
    chk("sel_not_yet_synced", sel_active, 0);
    step();
    chk("sel_loaded_paused", sel_active, 5);
    btn_pause = 1'b1;
    resume_at = 0; tick_at = 0;
    for (int k = 1; k <= 100 && tick_at == 0; k++) begin
      step();
      if (k == 12) btn_pause = 1'b0;
      if (paused === 1'b0 && resume_at == 0) resume_at = k;
      if (tick === 1'b1 && tick_at == 0) tick_at = k;
    end
    btn_pause = 1'b0;
    chk("first_tick_after_resume_sel5", tick_at - resume_at, 4);

    // Asynchronous reset clears a paused, fast-rate state between clock edges.
    sel = 3'd0;
    apply_reset(2);
    btn_pause = 1'b1;
    step_n(12);
    btn_pause = 1'b0;
    step_n(10);
    sel = 3'd6;
    step_n(5);
    chk("pre_reset_paused", paused, 1);
    chk("pre_reset_sel", sel_active, 6);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("async_clr_paused", paused, 0);
    chk("async_clr_sel", sel_active, 0);
    chk("async_clr_tick", tick, 0);
    sel = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // Reset mid-period (cnt=100) and mid-debounce discards history.
    step_n(97);
    btn_pause = 1'b1;
    step_n(3);
    btn_pause = 1'b0;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    chk("midreset_tick", tick, 0);
    reset = 1'b0;
    cyc = 0;
    wait_tick(200, n);
    chk("tick_after_midreset", n, 128);
    chk("no_toggle_after_reset", paused, 0);

    // Randomized traffic on sel and a bouncy button.
    apply_reset(2);
    len = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) sel = 3'($urandom_range(0, 7));
      if (len == 0) begin
        btn_pause = ($urandom_range(0, 1) == 1);
        len = $urandom_range(1, 14);
      end
      len--;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
